intr_sched: RTL and testbench

- Interrupt controller/scheduler for the single-cycle CPU datapath.
- Collects an external request and the timer request, latches them as pending, and arbitrates by fixed priority.
- Drives the datapath's two vector-select/push strobes, s_intr1 and s_intr2, for exactly one cycle per accepted interrupt.
- Blocks further interrupts until the control unit signals return-from-interrupt. Sits between the timer, the external pin and the control unit / datapath interface.

---
 rtl/intr_sched_pkg.sv | 13 +
 rtl/irq_edge_latch.sv | 58 +++++
 rtl/intr_sched.sv | 127 ++++++++++++
 tb/tb_intr_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/intr_sched_pkg.sv
// Shared encodings for the interrupt scheduler: FSM states and source indices.
package intr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam int SRC_EXT = 0;
  localparam int SRC_TMR = 1;

endpackage

// File: rtl/irq_edge_latch.sv
// One interrupt source: optional synchroniser, rising-edge detect, pending
// latch and a saturating counter of edges lost while already pending.
module irq_edge_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int OVR_W       = 4,
  parameter bit SYNC_EN     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             clr_i,
  output logic             pending_o,
  output logic [OVR_W-1:0] ovr_o
);

  logic             req_s;
  logic             req_q;
  logic             edge_c;
  logic             lost_c;
  logic             pending_q, pending_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  if (SYNC_EN) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
    assign req_s = sync_q[SYNC_STAGES-1];
  end else begin : g_bypass
    assign req_s = req_i;
  end

  // A new edge beats a same-cycle clear; an edge hitting a bit that stays set is lost.
  always_comb begin
    edge_c    = req_s & ~req_q;
    lost_c    = edge_c & pending_q & ~clr_i;
    pending_d = (pending_q & ~clr_i) | edge_c;
    ovr_d     = ovr_q;
    if (lost_c && (ovr_q != {OVR_W{1'b1}})) ovr_d = ovr_q + OVR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q     <= 1'b0;
      pending_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      req_q     <= req_s;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pending_o = pending_q;
  assign ovr_o     = ovr_q;

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: latches ext/timer requests, arbitrates by fixed priority
// (ext first) and issues one-cycle vector strobes, blocking until reti.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVR_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_ext,
  input  logic             irq_timer,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic [1:0]       mask,
  input  logic             reti,
  output logic             s_intr1,
  output logic             s_intr2,
  output logic             in_service,
  output logic             gie,
  output logic [1:0]       pending,
  output logic [OVR_W-1:0] ovr_ext,
  output logic [OVR_W-1:0] ovr_tmr
);

  state_e     state_q;
  logic       s_intr1_q, s_intr2_q, in_service_q;
  logic       gie_q, gie_d;
  logic [1:0] pend_c;
  logic [1:0] req_c;
  logic [1:0] clr_c;
  logic       take_c;
  logic       win_ext_c;

  irq_edge_latch #(
    .SYNC_STAGES (SYNC_STAGES),
    .OVR_W       (OVR_W),
    .SYNC_EN     (1'b1)
  ) u_ext (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (irq_ext),
    .clr_i     (clr_c[SRC_EXT]),
    .pending_o (pend_c[SRC_EXT]),
    .ovr_o     (ovr_ext)
  );

  irq_edge_latch #(
    .SYNC_STAGES (SYNC_STAGES),
    .OVR_W       (OVR_W),
    .SYNC_EN     (1'b0)
  ) u_tmr (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (irq_timer),
    .clr_i     (clr_c[SRC_TMR]),
    .pending_o (pend_c[SRC_TMR]),
    .ovr_o     (ovr_tmr)
  );

  // Arbitration: only from IDLE; the winner's pending bit clears on the take edge.
  always_comb begin
    req_c     = pend_c & mask;
    take_c    = (state_q == IDLE) && gie_q && (|req_c);
    win_ext_c = req_c[SRC_EXT];
    clr_c     = 2'b00;
    if (take_c) begin
      if (win_ext_c) clr_c[SRC_EXT] = 1'b1;
      else           clr_c[SRC_TMR] = 1'b1;
    end
  end

  always_comb begin
    gie_d = gie_q;
    if (ie_set) gie_d = 1'b1;
    if (ie_clr) gie_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) gie_q <= 1'b0;
    else        gie_q <= gie_d;
  end

  // Strobe registers double as the registered winner, so they are glitch-free
  // and can never both be high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      s_intr1_q    <= 1'b0;
      s_intr2_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      s_intr1_q <= 1'b0;
      s_intr2_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_c) begin
            state_q   <= TAKE;
            s_intr1_q <= win_ext_c;
            s_intr2_q <= ~win_ext_c;
          end
        end
        TAKE: begin
          state_q      <= SERVICE;
          in_service_q <= 1'b1;
        end
        SERVICE: begin
          if (reti) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_intr1    = s_intr1_q;
  assign s_intr2    = s_intr2_q;
  assign in_service = in_service_q;
  assign gie        = gie_q;
  assign pending    = pend_c;

endmodule

// File: tb/tb_intr_sched.sv
// Directed bench for intr_sched: a vector table for the basic flows plus
// hand-written sequences for overrun, clear/edge collision and mid-flight reset.
module tb_intr_sched;

  localparam int OVR_W = 4;
  localparam int NV    = 32;

  logic             clk;
  logic             reset;
  logic             irq_ext, irq_timer, ie_set, ie_clr, reti;
  logic [1:0]       mask;
  logic             s_intr1, s_intr2, in_service, gie;
  logic [1:0]       pending;
  logic [OVR_W-1:0] ovr_ext, ovr_tmr;

  int checks = 0;
  int errors = 0;

  intr_sched #(.SYNC_STAGES(2), .OVR_W(OVR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_ext    (irq_ext),
    .irq_timer  (irq_timer),
    .ie_set     (ie_set),
    .ie_clr     (ie_clr),
    .mask       (mask),
    .reti       (reti),
    .s_intr1    (s_intr1),
    .s_intr2    (s_intr2),
    .in_service (in_service),
    .gie        (gie),
    .pending    (pending),
    .ovr_ext    (ovr_ext),
    .ovr_tmr    (ovr_tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, ext, tmr, ies, iec;
    logic [1:0] msk;
    logic       rti;
    logic       s1, s2, isv, g;
    logic [1:0] pnd;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst_n, input logic ext, input logic tmr,
                              input logic ies, input logic iec, input logic [1:0] msk,
                              input logic rti, input logic s1, input logic s2,
                              input logic isv, input logic g, input logic [1:0] pnd);
    vec_t v;
    v.rst_n = rst_n; v.ext = ext; v.tmr = tmr; v.ies = ies; v.iec = iec;
    v.msk = msk; v.rti = rti; v.s1 = s1; v.s2 = s2; v.isv = isv; v.g = g; v.pnd = pnd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tmr();
    irq_timer = 1'b1;
    tick();
    irq_timer = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    irq_ext = 0; irq_timer = 0; ie_set = 0; ie_clr = 0; reti = 0; mask = 2'b11;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // rst ext tmr ies iec msk rti | s1 s2 isv gie pnd
    tbl[0]  = mk(0,0,1,0,0,2'b11,0, 0,0,0,0,2'b00);
    tbl[1]  = mk(0,0,0,0,0,2'b11,0, 0,0,0,0,2'b00);
    tbl[2]  = mk(0,0,1,0,0,2'b11,0, 0,0,0,0,2'b00);
    tbl[3]  = mk(1,0,0,0,0,2'b11,0, 0,0,0,0,2'b00);
    tbl[4]  = mk(1,0,1,0,0,2'b11,0, 0,0,0,0,2'b10);
    tbl[5]  = mk(1,0,0,0,0,2'b11,0, 0,0,0,0,2'b10);
    tbl[6]  = mk(1,0,0,0,0,2'b11,0, 0,0,0,0,2'b10);
    tbl[7]  = mk(1,0,0,1,0,2'b11,0, 0,0,0,1,2'b10);
    tbl[8]  = mk(1,0,0,0,0,2'b11,0, 0,1,0,1,2'b00);
    tbl[9]  = mk(1,0,0,0,0,2'b11,0, 0,0,1,1,2'b00);
    tbl[10] = mk(1,0,0,0,0,2'b11,0, 0,0,1,1,2'b00);
    tbl[11] = mk(1,0,0,0,0,2'b11,1, 0,0,0,1,2'b00);
    tbl[12] = mk(1,0,0,0,0,2'b11,0, 0,0,0,1,2'b00);
    // ext raised two cycles early so both pending bits latch on the same edge
    tbl[13] = mk(1,1,0,0,0,2'b11,0, 0,0,0,1,2'b00);
    tbl[14] = mk(1,1,0,0,0,2'b11,0, 0,0,0,1,2'b00);
    tbl[15] = mk(1,1,1,0,0,2'b11,0, 0,0,0,1,2'b11);
    tbl[16] = mk(1,1,1,0,0,2'b11,0, 1,0,0,1,2'b10);
    tbl[17] = mk(1,1,1,0,0,2'b11,0, 0,0,1,1,2'b10);
    tbl[18] = mk(1,1,1,0,0,2'b11,0, 0,0,1,1,2'b10);
    tbl[19] = mk(1,1,1,0,0,2'b11,1, 0,0,0,1,2'b10);
    tbl[20] = mk(1,1,1,0,0,2'b11,0, 0,1,0,1,2'b00);
    tbl[21] = mk(1,1,1,0,0,2'b11,0, 0,0,1,1,2'b00);
    tbl[22] = mk(1,1,1,0,0,2'b11,1, 0,0,0,1,2'b00);
    tbl[23] = mk(1,1,1,1,1,2'b11,0, 0,0,0,0,2'b00);
    tbl[24] = mk(1,1,1,0,0,2'b11,1, 0,0,0,0,2'b00);
    tbl[25] = mk(1,1,1,0,0,2'b11,0, 0,0,0,0,2'b00);
    tbl[26] = mk(1,0,0,1,0,2'b00,0, 0,0,0,1,2'b00);
    tbl[27] = mk(1,0,1,0,0,2'b00,0, 0,0,0,1,2'b10);
    tbl[28] = mk(1,0,1,0,0,2'b00,0, 0,0,0,1,2'b10);
    tbl[29] = mk(1,0,1,0,0,2'b10,0, 0,1,0,1,2'b00);
    tbl[30] = mk(1,0,1,0,0,2'b11,0, 0,0,1,1,2'b00);
    tbl[31] = mk(1,0,1,0,0,2'b11,1, 0,0,0,1,2'b00);

    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst_n; irq_ext = tbl[i].ext; irq_timer = tbl[i].tmr;
      ie_set = tbl[i].ies; ie_clr = tbl[i].iec; mask = tbl[i].msk; reti = tbl[i].rti;
      tick();
      chk($sformatf("v%0d s_intr1", i), 32'(s_intr1), 32'(tbl[i].s1));
      chk($sformatf("v%0d s_intr2", i), 32'(s_intr2), 32'(tbl[i].s2));
      chk($sformatf("v%0d in_service", i), 32'(in_service), 32'(tbl[i].isv));
      chk($sformatf("v%0d gie", i), 32'(gie), 32'(tbl[i].g));
      chk($sformatf("v%0d pending", i), 32'(pending), 32'(tbl[i].pnd));
    end
    chk("table ovr_tmr", 32'(ovr_tmr), 32'd0);
    chk("table ovr_ext", 32'(ovr_ext), 32'd0);

    // Overrun counting while in SERVICE, then saturation
    do_reset();
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq_timer = 1'b1; tick();
    irq_timer = 1'b0; tick();
    chk("ovr take s_intr2", 32'(s_intr2), 32'd1);
    tick();
    chk("ovr in_service", 32'(in_service), 32'd1);
    repeat (3) pulse_tmr();
    chk("ovr pending", 32'(pending), 32'b10);
    chk("ovr_tmr after 3", 32'(ovr_tmr), 32'd2);
    repeat (20) pulse_tmr();
    chk("ovr_tmr saturate", 32'(ovr_tmr), 32'hF);
    chk("ovr no nesting", 32'({s_intr1, s_intr2, in_service}), 32'b001);

    // Timer edge on the same edge as the take-clear of pending[1]
    do_reset();
    chk("coll ovr reset", 32'(ovr_tmr), 32'd0);
    pulse_tmr();
    chk("coll pending pre", 32'(pending), 32'b10);
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq_timer = 1'b1; tick();
    chk("coll s_intr2", 32'(s_intr2), 32'd1);
    chk("coll pending kept", 32'(pending), 32'b10);
    chk("coll ovr_tmr", 32'(ovr_tmr), 32'd0);
    irq_timer = 1'b0; tick();
    chk("coll in_service", 32'(in_service), 32'd1);
    reti = 1'b1; tick(); reti = 1'b0;
    chk("coll after reti", 32'({s_intr2, in_service}), 32'b00);
    tick();
    chk("coll second s_intr2", 32'(s_intr2), 32'd1);
    chk("coll pending clr", 32'(pending), 32'b00);
    tick();

    // Reset during SERVICE
    chk("rst svc pre", 32'(in_service), 32'd1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst svc outs", 32'({s_intr1, s_intr2, in_service, gie, pending}), 32'd0);
    tick();
    chk("rst svc after", 32'({s_intr1, s_intr2, in_service}), 32'd0);

    // Reset during TAKE
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    irq_timer = 1'b1; tick();
    irq_timer = 1'b0; tick();
    chk("rst take pre", 32'(s_intr2), 32'd1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst take outs", 32'({s_intr1, s_intr2, in_service, gie, pending}), 32'd0);
    tick();
    chk("rst take after", 32'({s_intr1, s_intr2, in_service}), 32'd0);

    // External path: synchroniser latency and overrun with gie off
    irq_ext = 1'b1; tick(); tick();
    chk("ext latency early", 32'(pending), 32'b00);
    tick();
    chk("ext latency", 32'(pending), 32'b01);
    irq_ext = 1'b0; repeat (3) tick();
    irq_ext = 1'b1; repeat (3) tick();
    irq_ext = 1'b0; repeat (3) tick();
    chk("ext pending", 32'(pending), 32'b01);
    chk("ovr_ext", 32'(ovr_ext), 32'd1);
    chk("ext no strobe", 32'({s_intr1, s_intr2}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
